// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON types: permutation state, tag width, tag reader FSM states
package ascon_pack;

    localparam int TAG_W = 128;

    // Word 0 is S0; the tag is built from S3 and S4.
    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } tag_fsm_e;

endpackage

// File: rtl/tag_reader.sv
// rtl/tag_reader.sv - captures {S3,S4} xor key as the tag, streams it MSB word first, optionally verifies it
module tag_reader
    import ascon_pack::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  type_state         state_i,
    input  logic [127:0]      key_i,
    input  logic              verify_i,
    input  logic [127:0]      tag_ref_i,
    output logic [WORD_W-1:0] word_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              tag_ok_o
);

    localparam int         N_WORDS  = TAG_W / WORD_W;
    localparam logic [1:0] LAST_IDX = 2'(N_WORDS - 1);

    tag_fsm_e         state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] ref_q, ref_d;
    logic             verify_q, verify_d;

    logic [TAG_W-1:0] tag_shifted;
    logic             unused_state;

    assign unused_state = ^{state_i[0], state_i[1], state_i[2]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        ref_d    = ref_q;
        verify_d = verify_q;
        case (state_q)
            ST_IDLE: begin
                // The only cycle in which the external state, key and reference are sampled.
                if (start_i) begin
                    tag_d    = {state_i[3], state_i[4]} ^ key_i;
                    ref_d    = tag_ref_i;
                    verify_d = verify_i;
                    idx_d    = 2'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 2'd0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            tag_q    <= '0;
            ref_q    <= '0;
            verify_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            ref_q    <= ref_d;
            verify_q <= verify_d;
        end
    end

    // Shift the current word up to the MSB end so index 0 selects tag[127:128-WORD_W].
    assign tag_shifted = tag_q << (int'(idx_q) * WORD_W);

    assign valid_o  = (state_q == ST_SEND);
    assign word_o   = valid_o ? tag_shifted[TAG_W-1 -: WORD_W] : '0;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign tag_ok_o = done_o && verify_q && (tag_q == ref_q);

endmodule

// File: doc/tag_reader.md
TAG_READER -- requirements
Module: tag_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning output word width in bits; legal values 32 and 64 only.
REQ-002 SHALL have port clock_i  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request to extract the tag from state_i.
REQ-005 SHALL have port state_i  input  type_state (5x64)  current ASCON state S0..S4.
REQ-006 SHALL have port key_i  input  128  cipher key K.
REQ-007 SHALL have port verify_i  input  1  high: compare against tag_ref_i; low: emit only.
REQ-008 SHALL have port tag_ref_i  input  128  received tag used in verify mode.
REQ-009 SHALL have port word_o  output  WORD_W  current tag word.
REQ-010 SHALL have port valid_o  output  1  word_o holds a valid word.
REQ-011 SHALL have port ready_i  input  1  downstream accepts word_o.
REQ-012 SHALL have port busy_o  output  1  capture or transmission in progress.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse at end of transfer.
REQ-014 SHALL have port tag_ok_o  output  1  verify result, valid while done_o is high.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, DONE.
REQ-016 SHALL, in IDLE with start_i=1, register tag = {S3,S4} XOR key_i (S3 upper 64 bits, key_i[127:64] on S3), register verify_i and tag_ref_i, clear word index, and go to SEND next cycle.
REQ-017 SHALL, in verify mode, set tag_ok_o = 1 at done only if the registered tag equals the registered tag_ref_i bit-for-bit, else 0.
REQ-018 SHALL, in emit mode, drive tag_ok_o = 0 at done.
REQ-019 SHALL, in SEND, drive valid_o=1 and word_o = tag word at index, MSB word first (index 0 = tag[127:128-WORD_W]).
REQ-020 SHALL advance index only when valid_o && ready_i; word_o SHALL stay stable while ready_i=0.
REQ-021 SHALL emit exactly 128/WORD_W words (4 or 2); the last handshake SHALL move the FSM to DONE.
REQ-022 SHALL, in DONE, pulse done_o for exactly one cycle, hold valid_o=0, and return to IDLE on the next cycle.
REQ-023 SHALL drive busy_o=1 in SEND and DONE, 0 in IDLE.
REQ-024 SHALL ignore start_i in SEND and DONE; the registered tag SHALL not change.
REQ-025 SHALL not sample state_i, key_i or tag_ref_i outside the IDLE start cycle.
REQ-026 SHALL allow start_i in the cycle after done_o (back-to-back transfers, one IDLE cycle minimum).
REQ-027 SHALL drive word_o = 0 whenever valid_o = 0.

Reset
REQ-028 SHALL, on reset_i=1 at a clock edge, go to IDLE with valid_o=0, busy_o=0, done_o=0, tag_ok_o=0, word_o=0, index=0, tag register=0.
REQ-029 SHALL abort any transfer on reset mid-SEND; no further words SHALL be emitted and done_o SHALL not pulse.
REQ-030 SHALL give reset priority over start_i in the same cycle.

Structure
REQ-031 SHALL take type_state from ascon_pack and add TAG_W=128 and the FSM enum type to ascon_pack.
REQ-032 SHALL be a single module with no sub-modules; the tag register SHALL use the same enable-controlled hold style as the state register.

Verification
REQ-033 SHALL check: S3=64'h0123456789ABCDEF, S4=64'hFEDCBA9876543210, key=0, ready_i=1, WORD_W=32 -> words 01234567, 89ABCDEF, FEDCBA98, 76543210 on four consecutive cycles, then done_o.
REQ-034 SHALL check: same state, key=128'hFFFF...FF, verify=1, tag_ref = bitwise inverse of {S3,S4} -> tag_ok_o=1 with done_o; flipping tag_ref bit 0 -> tag_ok_o=0.
REQ-035 SHALL check: ready_i toggled 1,0,0,1,... -> each word held stable during stalls, no word skipped or duplicated, exactly 4 handshakes.
REQ-036 SHALL check: start_i pulsed during SEND with different state_i -> original tag words emitted unchanged.
REQ-037 SHALL check: reset_i asserted after second handshake -> valid_o=0 next cycle, no done_o, then a fresh start produces a full correct transfer.
REQ-038 SHALL check: WORD_W=64, same stimulus as REQ-033 -> words 0123456789ABCDEF, FEDCBA9876543210, then done_o.
